// File: rtl/pw_entry_sequencer.sv
// Password lock front end: collects keypad digits, compares them with the stored password,
// handles re-programming after a good entry, inactivity timeout and failure lockout.
module pw_entry_sequencer #(
   parameter int                          DIGITS      = 4,
   parameter int                          DIGIT_W     = 4,
   parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_PW  = 16'h1234,
   parameter int                          TIMEOUT_CYC = 1000,
   parameter int                          MAX_FAIL    = 3,
   parameter int                          LOCKOUT_CYC = 5000,
   localparam int                         PW_W        = DIGITS*DIGIT_W,
   localparam int                         FC_W        = $clog2(MAX_FAIL+1),
   localparam int                         DC_W        = $clog2(DIGITS+1),
   localparam int                         TM_W        = $clog2(TIMEOUT_CYC+1),
   localparam int                         LK_W        = $clog2(LOCKOUT_CYC+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_valid,
   input  logic [DIGIT_W-1:0] key_code,
   output logic               key_ready,
   input  logic               key_clear,
   input  logic               prog_en,
   output logic               equal,
   output logic               result_valid,
   output logic               timeout,
   output logic               prog_done,
   output logic               locked,
   output logic [FC_W-1:0]    fail_cnt,
   output logic [DC_W-1:0]    digit_cnt
);

   typedef enum logic [2:0] {IDLE, COLLECT, PROG, COMPARE, RESULT, LOCKOUT} state_t;

   state_t                  state, state_n;
   logic [PW_W-1:0]         stored_pw, entry, entry_shift;
   logic [PW_W+DIGIT_W-1:0] entry_cat;
   logic [TM_W-1:0]         idle_tmr;
   logic [LK_W-1:0]         lock_tmr;
   logic                    auth;
   logic                    hs, last_digit, in_entry;
   logic                    do_shift, do_commit, do_tmo, do_abort;

   assign key_ready    = (state == IDLE) || (state == COLLECT) || (state == PROG);
   assign in_entry     = (state == COLLECT) || (state == PROG);
   assign hs           = key_valid & key_ready;
   assign result_valid = (state == RESULT);
   assign locked       = (state == LOCKOUT);
   // first-entered digit ends up in the MS position after DIGITS shifts
   assign entry_cat    = {entry, key_code};
   assign entry_shift  = entry_cat[PW_W-1:0];
   assign last_digit   = (state == IDLE) ? (DIGITS == 1) : (digit_cnt == DC_W'(DIGITS-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      do_shift  = 1'b0;
      do_commit = 1'b0;
      do_tmo    = 1'b0;
      do_abort  = 1'b0;
      case (state)
         IDLE: begin
            if (hs) begin
               do_shift = 1'b1;
               if (last_digit) begin
                  if (prog_en && auth) do_commit = 1'b1;
                  else                 state_n   = COMPARE;
               end else begin
                  state_n = (prog_en && auth) ? PROG : COLLECT;
               end
            end
         end
         COLLECT, PROG: begin
            // clear beats a handshake; a handshake beats the timeout
            if (key_clear) begin
               do_abort = 1'b1;
               state_n  = IDLE;
            end else if (hs) begin
               do_shift = 1'b1;
               if (last_digit) begin
                  if (state == PROG) begin
                     do_commit = 1'b1;
                     state_n   = IDLE;
                  end else begin
                     state_n = COMPARE;
                  end
               end
            end else if (idle_tmr == TM_W'(TIMEOUT_CYC-1)) begin
               do_tmo  = 1'b1;
               state_n = IDLE;
            end
         end
         COMPARE: state_n = RESULT;
         RESULT:  state_n = (!equal && (int'(fail_cnt) + 1 >= MAX_FAIL)) ? LOCKOUT : IDLE;
         LOCKOUT: if (lock_tmr == LK_W'(LOCKOUT_CYC-1)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stored_pw <= DEFAULT_PW;
         entry     <= '0;
         auth      <= 1'b0;
         equal     <= 1'b0;
         timeout   <= 1'b0;
         prog_done <= 1'b0;
         fail_cnt  <= '0;
         digit_cnt <= '0;
         idle_tmr  <= '0;
         lock_tmr  <= '0;
      end else begin
         timeout   <= do_tmo;
         prog_done <= do_commit;
         if (do_shift)  entry     <= entry_shift;
         if (do_commit) stored_pw <= entry_shift;

         if (do_abort || do_tmo || do_commit || state == COMPARE)
            digit_cnt <= '0;
         else if (do_shift && digit_cnt != DC_W'(DIGITS))
            digit_cnt <= digit_cnt + DC_W'(1);

         if (hs || !in_entry)                   idle_tmr <= '0;
         else if (idle_tmr != TM_W'(TIMEOUT_CYC)) idle_tmr <= idle_tmr + TM_W'(1);

         if (state == LOCKOUT) lock_tmr <= lock_tmr + LK_W'(1);
         else                  lock_tmr <= '0;

         if (state == COMPARE) equal <= (entry == stored_pw);

         if (state == RESULT)          auth <= equal;
         else if (do_commit || do_tmo) auth <= 1'b0;

         if (state == RESULT) begin
            if (equal)                          fail_cnt <= '0;
            else if (fail_cnt != FC_W'(MAX_FAIL)) fail_cnt <= fail_cnt + FC_W'(1);
         end else if (do_commit || (state == LOCKOUT && state_n == IDLE)) begin
            fail_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pw_entry_sequencer.sv
// Directed bench for pw_entry_sequencer: table of whole entries plus hand-written
// sequences for lockout, timeout, timer reload, key_clear and mid-entry reset.
module tb_pw_entry_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = '0;
   logic       key_ready;
   logic       key_clear = 1'b0;
   logic       prog_en = 1'b0;
   logic       equal, result_valid, timeout, prog_done, locked;
   logic [1:0] fail_cnt;
   logic [2:0] digit_cnt;

   int n_pass = 0;
   int n_total = 0;

   pw_entry_sequencer #(
      .DIGITS(4), .DIGIT_W(4), .DEFAULT_PW(16'h1234),
      .TIMEOUT_CYC(10), .MAX_FAIL(3), .LOCKOUT_CYC(20)
   ) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .key_clear(key_clear), .prog_en(prog_en),
      .equal(equal), .result_valid(result_valid), .timeout(timeout),
      .prog_done(prog_done), .locked(locked), .fail_cnt(fail_cnt),
      .digit_cnt(digit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        prog;
      logic [15:0] pw;
      logic        rv;
      logic        eq;
      logic        pd;
      logic [1:0]  fc;
   } vec_t;

   vec_t vecs[8];

   logic       r_rv1, r_rv2, r_pd1, r_eq2;
   logic [1:0] r_fc3;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else             n_pass++;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_one(input logic [3:0] d);
      key_valid = 1'b1;
      key_code  = d;
      tick();
      key_valid = 1'b0;
      prog_en   = 1'b0;
   endtask

   // Four back-to-back digits; samples T+1, T+2, T+3 after the last handshake (cycle T).
   task automatic do_entry(input logic prog, input logic [15:0] pw);
      prog_en = prog;
      for (int i = 0; i < 4; i++) begin
         key_valid = 1'b1;
         key_code  = pw[15-4*i -: 4];
         tick();
         prog_en = 1'b0;
      end
      key_valid = 1'b0;
      r_rv1 = result_valid;
      r_pd1 = prog_done;
      tick();
      r_rv2 = result_valid;
      r_eq2 = equal;
      tick();
      r_fc3 = fail_cnt;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 2'd0};
      vecs[1] = '{1'b0, 16'h1235, 1'b1, 1'b0, 1'b0, 2'd1};
      vecs[2] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 2'd0}; // prog_en without auth
      vecs[3] = '{1'b1, 16'h9876, 1'b0, 1'b1, 1'b1, 2'd0}; // program 9876
      vecs[4] = '{1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 2'd1};
      vecs[5] = '{1'b0, 16'h9876, 1'b1, 1'b1, 1'b0, 2'd0};
      vecs[6] = '{1'b1, 16'h5555, 1'b0, 1'b1, 1'b1, 2'd0}; // program 5555, auth cleared
      vecs[7] = '{1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 2'd0};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_key_ready", key_ready, 1);
      chk("rst_outputs", {equal, result_valid, timeout, prog_done, locked}, 0);
      chk("rst_counts", {fail_cnt, digit_cnt}, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", key_ready, 1);

      for (int v = 0; v < 8; v++) begin
         do_entry(vecs[v].prog, vecs[v].pw);
         chk($sformatf("v%0d_rv_T1", v), r_rv1, 0);
         chk($sformatf("v%0d_rv_T2", v), r_rv2, vecs[v].rv);
         chk($sformatf("v%0d_equal", v), r_eq2, vecs[v].eq);
         chk($sformatf("v%0d_prog_done", v), r_pd1, vecs[v].pd);
         chk($sformatf("v%0d_fail_cnt", v), r_fc3, vecs[v].fc);
      end

      // reset reverts the programmed password
      rst = 1'b1;
      tick();
      rst = 1'b0;
      do_entry(1'b0, 16'h1234);
      chk("revert_equal", r_eq2, 1);

      // three mismatches -> 20-cycle lockout
      for (int k = 1; k <= 3; k++) begin
         do_entry(1'b0, 16'h1235);
         chk($sformatf("lk_equal%0d", k), r_eq2, 0);
         chk($sformatf("lk_fail%0d", k), r_fc3, k);
      end
      chk("lk_ready_low", key_ready, 0);
      key_valid = 1'b1;
      key_code  = 4'h1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) key_valid = 1'b0;
         chk($sformatf("lk_locked%0d", i), locked, 1);
         tick();
      end
      chk("lk_released", locked, 0);
      chk("lk_ready_back", key_ready, 1);
      chk("lk_fail_cleared", fail_cnt, 0);
      chk("lk_digits_ignored", digit_cnt, 0);

      // inactivity timeout after two digits
      send_one(4'h1);
      send_one(4'h2);
      chk("to_digit_cnt2", digit_cnt, 2);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("to_quiet%0d", i), {timeout, result_valid}, 0);
         tick();
      end
      chk("to_pulse", timeout, 1);
      chk("to_digit_cnt0", digit_cnt, 0);
      chk("to_ready", key_ready, 1);
      tick();
      chk("to_pulse_one_cycle", timeout, 0);
      do_entry(1'b0, 16'h1234);
      chk("to_next_equal", r_eq2, 1);
      chk("to_next_rv", r_rv2, 1);

      // handshakes reload the timer; handshake on the expiry cycle wins
      send_one(4'h1);
      repeat (8) tick();
      send_one(4'h2);
      repeat (9) tick();
      send_one(4'h3);
      chk("rl_no_timeout", timeout, 0);
      chk("rl_digit_cnt3", digit_cnt, 3);
      send_one(4'h4);
      chk("rl_rv_T1", result_valid, 0);
      tick();
      chk("rl_rv_T2", result_valid, 1);
      chk("rl_equal", equal, 1);
      tick();

      // key_clear with the 2nd digit drops the entry
      send_one(4'h1);
      key_clear = 1'b1;
      send_one(4'h2);
      key_clear = 1'b0;
      chk("clr_digit_cnt", digit_cnt, 0);
      chk("clr_ready", key_ready, 1);
      chk("clr_no_pulses", {timeout, prog_done, result_valid}, 0);
      do_entry(1'b0, 16'h1234);
      chk("clr_next_equal", r_eq2, 1);
      chk("clr_next_rv", r_rv2, 1);

      // reset during a programming entry
      prog_en = 1'b1;
      send_one(4'h9);
      send_one(4'h8);
      chk("pr_digit_cnt2", digit_cnt, 2);
      #2 rst = 1'b1;
      #1;
      chk("pr_rst_ready", key_ready, 1);
      chk("pr_rst_digit_cnt", digit_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_entry(1'b0, 16'h1234);
      chk("pr_after_equal", r_eq2, 1);
      chk("pr_after_rv", r_rv2, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
